// File: rtl/up_int_ctrl_pkg.sv
// Shared types and constants for the up_core interrupt controller.
// Optional build macro used by this slice: UP_INT_CTRL_RR_EN (round-robin priority).
package up_int_ctrl_pkg;

   localparam int unsigned MAX_SRC = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ASSERT   = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   localparam logic [1:0] CFG_MASK   = 2'd0;
   localparam logic [1:0] CFG_ACK    = 2'd1;
   localparam logic [1:0] CFG_SWTRIG = 2'd2;

   localparam int unsigned ST_BUSY     = 8;
   localparam int unsigned ST_PEND_LSB = 4;
   localparam int unsigned ST_VALID    = 2;
   localparam int unsigned ST_ID_LSB   = 0;

   function automatic logic [8:0] pack_status(input logic       busy,
                                              input logic [3:0] pend,
                                              input logic       valid,
                                              input logic [1:0] id);
      logic [8:0] st;
      st                      = '0;
      st[ST_BUSY]             = busy;
      st[ST_PEND_LSB +: 4]    = pend;
      st[ST_VALID]            = valid;
      st[ST_ID_LSB +: 2]      = id;
      return st;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == '1) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/up_int_ctrl_if.sv
// Core-side bus of the interrupt controller: source requests, config write port,
// status word and the active-low interrupt line.
interface up_int_ctrl_if;
   import up_int_ctrl_pkg::*;

   logic [MAX_SRC-1:0] irq;
   logic               cfg_wr;
   logic [1:0]         cfg_addr;
   logic [7:0]         cfg_wdata;
   logic [8:0]         status;
   logic               int_n;

   modport master (
      output irq, cfg_wr, cfg_addr, cfg_wdata,
      input  status, int_n
   );

   modport slave (
      input  irq, cfg_wr, cfg_addr, cfg_wdata,
      output status, int_n
   );

endinterface

// File: rtl/up_int_prio.sv
// Combinational source picker: fixed lowest-index priority, or round-robin
// starting after last_id when UP_INT_CTRL_RR_EN is defined.
module up_int_prio
   import up_int_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC = 4
) (
   input  logic [N_SRC-1:0] cand,
`ifdef UP_INT_CTRL_RR_EN
   input  logic [1:0]       last_id,
`endif
   output logic             valid,
   output logic [1:0]       id
);

`ifdef UP_INT_CTRL_RR_EN
   logic       hi_found;
   logic       lo_found;
   logic [1:0] hi_id;
   logic [1:0] lo_id;

   // Lowest candidate above last_id wins; otherwise wrap to lowest overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_id    = '0;
      lo_id    = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (cand[i] && !lo_found) begin
            lo_found = 1'b1;
            lo_id    = 2'(i);
         end
         if (cand[i] && !hi_found && (2'(i) > last_id)) begin
            hi_found = 1'b1;
            hi_id    = 2'(i);
         end
      end
      valid = lo_found;
      id    = hi_found ? hi_id : lo_id;
   end
`else
   logic found;

   always_comb begin
      found = 1'b0;
      id    = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (cand[i] && !found) begin
            found = 1'b1;
            id    = 2'(i);
         end
      end
      valid = found;
   end
`endif

endmodule

// File: rtl/up_int_ctrl.sv
// Interrupt controller for up_core: edge-latched sources, priority pick, fixed
// int_n pulse, then wait for ack. Optional macro: UP_INT_CTRL_RR_EN.
module up_int_ctrl
   import up_int_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC       = 4,
   parameter int unsigned PULSE_LEN   = 50,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst,
   up_int_ctrl_if.slave bus
);

   localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
   localparam logic [7:0] TMO_LAST   = 8'(ACK_TIMEOUT - 1);

   logic [N_SRC-1:0] irq_q;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] wdata_src;
   logic [N_SRC-1:0] edge_set;
   logic [N_SRC-1:0] ack_clr;
   logic [N_SRC-1:0] sw_set;
   logic [N_SRC-1:0] cand;
   logic             mask_wr;

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic [1:0] act_id, act_id_nx;
   logic       act_valid, act_valid_nx;
   logic [8:0] status_q;

   logic       pick_valid;
   logic [1:0] pick_id;

   assign wdata_src = bus.cfg_wdata[N_SRC-1:0];
   assign edge_set  = bus.irq[N_SRC-1:0] & ~irq_q;
   assign mask_wr   = bus.cfg_wr && (bus.cfg_addr == CFG_MASK);
   assign ack_clr   = (bus.cfg_wr && (bus.cfg_addr == CFG_ACK))    ? wdata_src : '0;
   assign sw_set    = (bus.cfg_wr && (bus.cfg_addr == CFG_SWTRIG)) ? wdata_src : '0;
   assign cand      = pending & mask;

`ifdef UP_INT_CTRL_RR_EN
   logic [1:0] last_id;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_id <= 2'(N_SRC - 1);
      end else if ((state == WAIT_ACK) && (state_nx == IDLE)) begin
         last_id <= act_id;
      end
   end

   up_int_prio #(.N_SRC(N_SRC)) u_prio (
      .cand    (cand),
      .last_id (last_id),
      .valid   (pick_valid),
      .id      (pick_id)
   );
`else
   up_int_prio #(.N_SRC(N_SRC)) u_prio (
      .cand  (cand),
      .valid (pick_valid),
      .id    (pick_id)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q     <= '0;
         pending   <= '0;
         mask      <= '0;
         state     <= IDLE;
         cnt       <= '0;
         act_id    <= '0;
         act_valid <= 1'b0;
         status_q  <= '0;
      end else begin
         irq_q     <= bus.irq[N_SRC-1:0];
         // New edges and software triggers take precedence over an ACK clear.
         pending   <= (pending & ~ack_clr) | edge_set | sw_set;
         if (mask_wr) begin
            mask <= wdata_src;
         end
         state     <= state_nx;
         cnt       <= cnt_nx;
         act_id    <= act_id_nx;
         act_valid <= act_valid_nx;
         status_q  <= pack_status(state != IDLE, 4'(pending), act_valid, act_id);
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      act_id_nx    = act_id;
      act_valid_nx = act_valid;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_nx     = ASSERT;
               act_id_nx    = pick_id;
               act_valid_nx = 1'b1;
               cnt_nx       = '0;
            end
         end
         ASSERT: begin
            if (cnt == PULSE_LAST) begin
               state_nx = WAIT_ACK;
               cnt_nx   = '0;
            end else begin
               cnt_nx = sat_inc(cnt);
            end
         end
         WAIT_ACK: begin
            // Mask is not rechecked here: a started service ends only on ack.
            if (!pending[act_id]) begin
               state_nx     = IDLE;
               act_id_nx    = '0;
               act_valid_nx = 1'b0;
               cnt_nx       = '0;
            end else if (cnt == TMO_LAST) begin
               state_nx = ASSERT;
               cnt_nx   = '0;
            end else begin
               cnt_nx = sat_inc(cnt);
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.int_n  = (state != ASSERT);
   assign bus.status = status_q;

endmodule

// File: tb/tb_up_int_ctrl.sv
// Directed scoreboard bench for up_int_ctrl (N_SRC=4, PULSE_LEN=50, ACK_TIMEOUT=255).
module tb_up_int_ctrl;
   import up_int_ctrl_pkg::*;

   localparam int unsigned PL = 50;
   localparam int unsigned TO = 255;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   up_int_ctrl_if bus ();

   up_int_ctrl #(
      .N_SRC       (4),
      .PULSE_LEN   (PL),
      .ACK_TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   sb_item_t    sb[$];
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input string tag, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb.push_back(it);
   endtask

   task automatic sb_check(input logic [31:0] obs);
      sb_item_t it;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL sb_empty: observed %0h required an expectation entry", obs);
      end else begin
         it = sb.pop_front();
         assert (obs === it.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
         end
      end
   endtask

   task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
      bus.cfg_wr    = 1'b1;
      bus.cfg_addr  = addr;
      bus.cfg_wdata = data;
      tick();
      bus.cfg_wr    = 1'b0;
      bus.cfg_wdata = '0;
   endtask

   task automatic wait_lvl(input logic lvl, input int unsigned budget, output int unsigned n);
      n = 0;
      while (bus.int_n !== lvl && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic measure(input logic lvl, input int unsigned limit, output int unsigned n);
      n = 0;
      while (bus.int_n === lvl && n < limit) begin
         n++;
         tick();
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      rst           = 1'b1;
      bus.irq       = '0;
      bus.cfg_wr    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_wdata = '0;

      // Reset state
      sb_push("rst_status", 32'h000);
      sb_push("rst_int_n", 32'd1);
      repeat (3) tick();
      sb_check(bus.status);
      sb_check(bus.int_n);
      rst = 1'b0;
      tick();

      // 1: single source, latency, pulse width, status, ack
      cfg_write(CFG_MASK, 8'h01);
      bus.irq[0] = 1'b1;
      sb_push("t1_int_edge_k", 32'd1);
      sb_push("t1_int_edge_k1", 32'd0);
      sb_push("t1_pulse_len", PL);
      sb_push("t1_status_busy", 32'h114);
      sb_push("t1_status_acked", 32'h000);
      tick();
      sb_check(bus.int_n);
      tick();
      sb_check(bus.int_n);
      measure(1'b0, 1000, n);
      sb_check(n);
      sb_check(bus.status);
      cfg_write(CFG_ACK, 8'h01);
      repeat (2) tick();
      sb_check(bus.status);
      bus.irq[0] = 1'b0;
      tick();

      // 2: simultaneous sources, lowest index first, then the other
      cfg_write(CFG_MASK, 8'h0F);
      bus.irq[2:1] = 2'b11;
      sb_push("t2_latency", 32'd2);
      sb_push("t2_first_id1", 32'h165);
      sb_push("t2_gap", 32'd2);
      sb_push("t2_second_id2", 32'h146);
      sb_push("t2_done", 32'h000);
      wait_lvl(1'b0, 20, n);
      sb_check(n);
      tick();
      sb_check(bus.status);
      measure(1'b0, 200, n);
      cfg_write(CFG_ACK, 8'h02);
      wait_lvl(1'b0, 20, n);
      sb_check(n);
      tick();
      sb_check(bus.status);
      measure(1'b0, 200, n);
      cfg_write(CFG_ACK, 8'h04);
      repeat (2) tick();
      sb_check(bus.status);
      bus.irq[2:1] = 2'b00;
      tick();

`ifdef UP_INT_CTRL_RR_EN
      // 2b: round-robin with last_id=1 picks id2 ahead of id1
      cfg_write(CFG_SWTRIG, 8'h02);
      wait_lvl(1'b0, 20, n);
      measure(1'b0, 200, n);
      cfg_write(CFG_ACK, 8'h02);
      repeat (2) tick();
      cfg_write(CFG_SWTRIG, 8'h06);
      sb_push("t2rr_first_id2", 32'h166);
      wait_lvl(1'b0, 20, n);
      tick();
      sb_check(bus.status);
      measure(1'b0, 200, n);
      cfg_write(CFG_ACK, 8'h06);
      repeat (2) tick();
`endif

      // 3: no ack -> re-pulse after timeout; ack stops it
      cfg_write(CFG_MASK, 8'h01);
      cfg_write(CFG_SWTRIG, 8'h01);
      sb_push("t3_pulse1", PL);
      sb_push("t3_gap", TO);
      sb_push("t3_pulse2", PL);
      sb_push("t3_quiet", 32'd400);
      sb_push("t3_idle", 32'h000);
      wait_lvl(1'b0, 20, n);
      measure(1'b0, 1000, n);
      sb_check(n);
      measure(1'b1, 1000, n);
      sb_check(n);
      measure(1'b0, 1000, n);
      sb_check(n);
      cfg_write(CFG_ACK, 8'h01);
      measure(1'b1, 400, n);
      sb_check(n);
      sb_check(bus.status);

      // 4: ack and new edge in the same cycle -> set wins, source re-serviced
      cfg_write(CFG_MASK, 8'h08);
      bus.irq[3] = 1'b1;
      sb_push("t4_pending_kept", 32'h187);
      sb_push("t4_repulse", 32'd0);
      sb_push("t4_ack_in_assert", 32'h000);
      wait_lvl(1'b0, 20, n);
      measure(1'b0, 200, n);
      bus.irq[3] = 1'b0;
      tick();
      bus.irq[3] = 1'b1;
      cfg_write(CFG_ACK, 8'h08);
      tick();
      sb_check(bus.status);
      wait_lvl(1'b0, 300, n);
      sb_check(bus.int_n);
      bus.irq[3] = 1'b0;
      cfg_write(CFG_ACK, 8'h08);
      wait_lvl(1'b1, 100, n);
      repeat (2) tick();
      sb_check(bus.status);

      // 5: reset mid-pulse; irq held high afterwards raises no interrupt
      cfg_write(CFG_MASK, 8'h01);
      bus.irq[0] = 1'b1;
      sb_push("t5_int_n_after_rst", 32'd1);
      sb_push("t5_status_after_rst", 32'h000);
      sb_push("t5_quiet", 32'd100);
      wait_lvl(1'b0, 20, n);
      repeat (9) tick();
      rst = 1'b1;
      tick();
      sb_check(bus.int_n);
      sb_check(bus.status);
      rst = 1'b0;
      measure(1'b1, 100, n);
      sb_check(n);
      bus.irq[0] = 1'b0;
      cfg_write(CFG_ACK, 8'h0F);
      tick();

      // 6: masked software trigger, then unmask starts pulse one cycle later
      cfg_write(CFG_SWTRIG, 8'h04);
      sb_push("t6_status_pend", 32'h040);
      sb_push("t6_masked_no_pulse", 32'd1);
      sb_push("t6_int_at_mask_wr", 32'd1);
      sb_push("t6_int_after_mask", 32'd0);
      sb_push("t6_pulse_len", PL);
      sb_push("t6_done", 32'h000);
      tick();
      sb_check(bus.status);
      sb_check(bus.int_n);
      cfg_write(CFG_MASK, 8'h04);
      sb_check(bus.int_n);
      tick();
      sb_check(bus.int_n);
      measure(1'b0, 200, n);
      sb_check(n);
      cfg_write(CFG_ACK, 8'h04);
      repeat (2) tick();
      sb_check(bus.status);

      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: observed %0d pending entries, required 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
